multi3_arbiter: RTL

//  Shares one sequential shift-add multiplier (WIDTH x WIDTH -> 2*WIDTH) among NREQ requesters.
//  - Round-robin arbitration; latches the winner's operands.
//  - Runs one partial product per cycle, then returns the product tagged with the requester id.
//  - Sits between requester blocks and the shared product consumer. One product in flight at a time.

---
 rtl/multi3_pkg.sv | 22 ++
 rtl/multi3_rr_pick.sv | 37 +++
 rtl/multi3_arbiter.sv | 119 +++++++++++
 3 files changed

// File: rtl/multi3_pkg.sv
// Shared FSM encoding and id-width helper for the shared multiplier arbiter.
package multi3_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Ceiling log2, never less than 1 so single-entry fields stay legal.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) begin
                r = i + 1;
            end
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/multi3_rr_pick.sv
// Round-robin picker: first set request at or after ptr, wrapping modulo NREQ.
// Purely combinational; zero latency, no backpressure of its own.
module multi3_rr_pick
    import multi3_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] onehot,
    output logic [IDW-1:0]  id,
    output logic            any
);

    // First pass covers ptr..NREQ-1, second pass picks up the wrapped part.
    always_comb begin
        onehot = '0;
        id     = '0;
        any    = 1'b0;
        for (int j = 0; j < NREQ; j++) begin
            if (!any && req[j] && (j >= int'(ptr))) begin
                any       = 1'b1;
                onehot[j] = 1'b1;
                id        = IDW'(j);
            end
        end
        for (int j = 0; j < NREQ; j++) begin
            if (!any && req[j]) begin
                any       = 1'b1;
                onehot[j] = 1'b1;
                id        = IDW'(j);
            end
        end
    end

endmodule

// File: rtl/multi3_arbiter.sv
// Round-robin shared shift-add multiplier; gnt one cycle after req, product WIDTH cycles later.
// res_valid holds in DONE until res_ready; no new grant meanwhile (MULTI3_ARB_EARLY_TERM_EN shortens CALC).
module multi3_arbiter
    import multi3_pkg::*;
#(
    parameter int  NREQ  = 4,
    parameter int  WIDTH = 3,
    localparam int IDW   = clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] a_flat,
    input  logic [NREQ*WIDTH-1:0] b_flat,
    output logic [NREQ-1:0]       gnt,
    output logic                  busy,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [IDW-1:0]        res_id,
    output logic [2*WIDTH-1:0]    result
);

    localparam int STW = clog2(WIDTH);

    state_t             state;
    logic [IDW-1:0]     ptr;
    logic [IDW-1:0]     win_id;
    logic [WIDTH-1:0]   a_sh;
    logic [2*WIDTH-1:0] b_sh;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_next;
    logic [STW-1:0]     step;
    logic               last_step;
    logic [IDW-1:0]     ptr_next;

    logic [NREQ-1:0]    pick_oh;
    logic [IDW-1:0]     pick_id;
    logic               pick_any;

    multi3_rr_pick #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_pick (
        .req    (req),
        .ptr    (ptr),
        .onehot (pick_oh),
        .id     (pick_id),
        .any    (pick_any)
    );

    assign acc_next = a_sh[0] ? (acc + b_sh) : acc;
    assign ptr_next = (win_id == IDW'(NREQ - 1)) ? '0 : (win_id + 1'b1);

`ifdef MULTI3_ARB_EARLY_TERM_EN
    // Stop once no set multiplier bits remain after this step's shift.
    assign last_step = (step == STW'(WIDTH - 1)) || ((a_sh >> 1) == '0);
`else
    assign last_step = (step == STW'(WIDTH - 1));
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= '0;
            win_id    <= '0;
            a_sh      <= '0;
            b_sh      <= '0;
            acc       <= '0;
            step      <= '0;
            gnt       <= '0;
            busy      <= 1'b0;
            res_valid <= 1'b0;
            res_id    <= '0;
            result    <= '0;
        end else begin
            gnt <= '0;
            case (state)
                IDLE: begin
                    if (pick_any) begin
                        state  <= CALC;
                        busy   <= 1'b1;
                        gnt    <= pick_oh;
                        win_id <= pick_id;
                        a_sh   <= a_flat[int'(pick_id)*WIDTH +: WIDTH];
                        b_sh   <= {{WIDTH{1'b0}}, b_flat[int'(pick_id)*WIDTH +: WIDTH]};
                        acc    <= '0;
                        step   <= '0;
                    end
                end
                CALC: begin
                    acc  <= acc_next;
                    a_sh <= a_sh >> 1;
                    b_sh <= b_sh << 1;
                    step <= step + 1'b1;
                    if (last_step) begin
                        state     <= DONE;
                        res_valid <= 1'b1;
                        result    <= acc_next;
                        res_id    <= win_id;
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        state     <= IDLE;
                        busy      <= 1'b0;
                        res_valid <= 1'b0;
                        ptr       <= ptr_next;
                    end
                end
                default: begin
                    state     <= IDLE;
                    busy      <= 1'b0;
                    res_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
